serial_subtractor: RTL and testbench

Parametrised multi-cycle subtractor. Computes diff = a - b - borrow_in over WIDTH-bit operands, DIGIT_W bits per clock, with the borrow carried between cycles in a flop. It uses a valid/ready handshake on both input and output. It is the sequential successor to the single-bit subtractor cells and trades latency for area in wide datapaths.

---
 rtl/adder_subtractor_pkg.sv | 16 +
 rtl/digit_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 141 ++++++++++++++
 tb/tb_serial_subtractor.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_subtractor_pkg.sv
// Shared types and elaboration helpers for the serial subtractor family.
package adder_subtractor_pkg;

  // Control states of the digit-serial subtractor.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // True when the operand width splits into a whole number of digits.
  function automatic bit digit_cfg_ok(input int width, input int digit_w);
    return (digit_w > 0) && (width >= digit_w) && ((width % digit_w) == 0);
  endfunction

endpackage

// File: rtl/digit_subtractor.sv
// Combinational DIGIT_W-bit subtractor built as a ripple of single-bit
// difference/borrow cells: {bout, d} = a - b - bin.
module digit_subtractor #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  // borrow_chain[i] is the borrow into bit i; the top entry is the digit borrow-out.
  logic [DIGIT_W:0] borrow_chain;

  assign borrow_chain[0] = bin;

  for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_bit
    assign d[gi]              = a[gi] ^ b[gi] ^ borrow_chain[gi];
    assign borrow_chain[gi+1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & borrow_chain[gi]);
  end

  assign bout = borrow_chain[DIGIT_W];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - borrow_in, DIGIT_W bits per clock,
// LSB digit first, with valid/ready handshakes on both sides.
module serial_subtractor
  import adder_subtractor_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DIGIT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             ovf_o
);

  localparam int NUM_DIGITS = WIDTH / DIGIT_W;
  localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

  if (!digit_cfg_ok(WIDTH, DIGIT_W)) begin : g_bad_cfg
    $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT_W");
  end

  sub_state_e       state_reg;
  sub_state_e       state_next;

  // Operand shift registers; the low digit is always the one being processed.
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  // Partial result, filled from the MSB end so it is aligned after the last digit.
  logic [WIDTH-1:0] res_reg;
  logic             borrow_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;

  // Output registers, only rewritten on the transition into DONE.
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg;
  logic             ovf_reg;

  logic [DIGIT_W-1:0] dig_d;
  logic               dig_bout;
  logic [WIDTH-1:0]   res_shifted;
  logic               last_digit;

  digit_subtractor #(
    .DIGIT_W(DIGIT_W)
  ) u_digit (
    .a   (a_sh_reg[DIGIT_W-1:0]),
    .b   (b_sh_reg[DIGIT_W-1:0]),
    .bin (borrow_reg),
    .d   (dig_d),
    .bout(dig_bout)
  );

  // With a single digit there is nothing older to shift down.
  if (NUM_DIGITS == 1) begin : g_single
    assign res_shifted = dig_d;
  end else begin : g_multi
    assign res_shifted = {dig_d, res_reg[WIDTH-1:DIGIT_W]};
  end

  assign last_digit  = (cnt_reg == LAST_DIGIT);
  assign in_ready_o  = (state_reg == IDLE) && !rst_i;
  assign out_valid_o = (state_reg == DONE);
  assign diff_o      = diff_reg;
  assign borrow_o    = borrow_out_reg;
  assign ovf_o       = ovf_reg;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept in IDLE, one digit per BUSY cycle, hold in DONE until taken.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid_i)  state_next = BUSY;
      BUSY:    if (last_digit)  state_next = DONE;
      DONE:    if (out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load operands on accept, consume one digit per BUSY cycle, publish on the last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sh_reg       <= '0;
      b_sh_reg       <= '0;
      res_reg        <= '0;
      borrow_reg     <= 1'b0;
      cnt_reg        <= '0;
      a_msb_reg      <= 1'b0;
      b_msb_reg      <= 1'b0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid_i) begin
            a_sh_reg   <= a_i;
            b_sh_reg   <= b_i;
            borrow_reg <= borrow_i;
            cnt_reg    <= '0;
            a_msb_reg  <= a_i[WIDTH-1];
            b_msb_reg  <= b_i[WIDTH-1];
          end
        end
        BUSY: begin
          a_sh_reg   <= a_sh_reg >> DIGIT_W;
          b_sh_reg   <= b_sh_reg >> DIGIT_W;
          res_reg    <= res_shifted;
          borrow_reg <= dig_bout;
          cnt_reg    <= cnt_reg + 1'b1;
          if (last_digit) begin
            diff_reg       <= res_shifted;
            borrow_out_reg <= dig_bout;
            // The last digit carries the result sign bit in its top position.
            ovf_reg        <= (a_msb_reg != b_msb_reg) && (dig_d[DIGIT_W-1] != a_msb_reg);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed and random traffic on an
// 8/4 instance plus random sweeps on 8/1, 32/32 and 32/8 instances.
module tb_serial_subtractor;

  typedef struct {
    logic [31:0] diff;
    logic        bo;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   lanes_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic lane_finished();
    lanes_done++;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic bin);
    exp_t   e;
    longint m, ua, ub, u, sa, sb, r, bi;
    m  = longint'(1) << w;
    ua = {32'b0, a};
    ub = {32'b0, b};
    ua = ua & (m - 1);
    ub = ub & (m - 1);
    bi = bin ? m / m : m - m;
    u  = ua - ub - bi;
    e.bo   = (u < 0);
    e.diff = 32'((u + m) % m);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = sa - sb - bi;
    e.ovf  = (r < -(m / 2)) || (r >= m / 2);
    e.acc  = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] d, input logic bo, input logic ovf);
    exp_t e;
    e.diff = d;
    e.bo   = bo;
    e.ovf  = ovf;
    e.acc  = 0;
    return e;
  endfunction

  // ---------------- main 8/4 instance ----------------
  logic       m_rst, m_iv, m_ir, m_bin, m_ov, m_or, m_bo, m_ovf;
  logic [7:0] m_a, m_b, m_diff;
  logic       rand_rdy, rdy_force;
  exp_t       mq[$];

  serial_subtractor #(.WIDTH(8), .DIGIT_W(4)) u_dut (
    .clk_i(clk), .rst_i(m_rst), .in_valid_i(m_iv), .in_ready_o(m_ir),
    .a_i(m_a), .b_i(m_b), .borrow_i(m_bin), .out_valid_o(m_ov),
    .out_ready_i(m_or), .diff_o(m_diff), .borrow_o(m_bo), .ovf_o(m_ovf)
  );

  logic [7:0] dt_a  [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
  logic [7:0] dt_b  [5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
  logic       dt_bin[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] dt_d  [5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
  logic       dt_bo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       dt_ov [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic main_issue(input logic [7:0] a, input logic [7:0] b, input logic bin,
                            input exp_t e);
    int   n;
    exp_t ee;
    m_a = a; m_b = b; m_bin = bin; m_iv = 1'b1;
    n = 0;
    while (!m_ir && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("main_accept_ready", 64'(m_ir), 64'd1);
    if (m_ir) begin
      ee = e;
      ee.acc = cyc + 1;
      mq.push_back(ee);
    end
    @(negedge clk);
    m_iv = 1'b0; m_a = 8'($urandom); m_b = 8'($urandom); m_bin = 1'($urandom);
  endtask

  task automatic main_wait_valid();
    int n;
    n = 0;
    while (!m_ov && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("main_valid_seen", 64'(m_ov), 64'd1);
  endtask

  // Consumer ready: fixed level for directed phases, random otherwise.
  initial begin
    m_or = 1'b1;
    forever begin
      @(negedge clk);
      m_or = rand_rdy ? 1'($urandom) : rdy_force;
    end
  end

  // Main monitor: latency on rise, hold-stable under backpressure, compare on handshake.
  initial begin
    logic       pv, pb, po;
    logic [7:0] pd;
    exp_t       e;
    pv = 1'b0; pb = 1'b0; po = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (m_ov && !pv) begin
        if (mq.size() > 0) chk("main_latency", 64'(cyc - mq[0].acc), 64'd2);
        else chk("main_spurious_valid", 64'(m_ov), 64'd0);
      end
      if (m_ov && pv) begin
        chk("main_hold_diff", 64'(m_diff), 64'(pd));
        chk("main_hold_borrow", 64'(m_bo), 64'(pb));
        chk("main_hold_ovf", 64'(m_ovf), 64'(po));
      end
      if (m_ov && m_or && mq.size() > 0) begin
        e = mq.pop_front();
        chk("main_diff", 64'(m_diff), 64'(e.diff));
        chk("main_borrow", 64'(m_bo), 64'(e.bo));
        chk("main_ovf", 64'(m_ovf), 64'(e.ovf));
        $display("main op done: diff=0x%02h borrow=%0b ovf=%0b", m_diff, m_bo, m_ovf);
      end
      pv = m_ov; pd = m_diff; pb = m_bo; po = m_ovf;
    end
  end

  // Main stimulus: reset, directed table, backpressure, mid-op reset, random.
  initial begin
    int         n;
    logic [7:0] ra, rb;
    logic       rbin;
    m_rst = 1'b1; m_iv = 1'b0; m_a = '0; m_b = '0; m_bin = 1'b0;
    rand_rdy = 1'b0; rdy_force = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(m_ov), 64'd0);
    chk("reset_diff", 64'(m_diff), 64'd0);
    chk("reset_borrow", 64'(m_bo), 64'd0);
    chk("reset_ovf", 64'(m_ovf), 64'd0);
    chk("reset_in_ready", 64'(m_ir), 64'd0);
    m_rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(m_ir), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      main_issue(dt_a[i], dt_b[i], dt_bin[i], mk(32'(dt_d[i]), dt_bo[i], dt_ov[i]));
      main_wait_valid();
      @(negedge clk);
      chk("ready_after_done", 64'(m_ir), 64'd1);
    end

    rdy_force = 1'b0;
    repeat (2) @(negedge clk);
    main_issue(8'h3C, 8'h5A, 1'b1, mk(32'hE1, 1'b1, 1'b0));
    main_wait_valid();
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready", 64'(m_ir), 64'd0);
      chk("bp_out_valid", 64'(m_ov), 64'd1);
      m_iv = (k % 2 == 0); m_a = 8'hFF; m_b = 8'h00; m_bin = 1'b1;
      @(negedge clk);
    end
    m_iv = 1'b0;
    rdy_force = 1'b1;
    main_issue(8'h80, 8'h01, 1'b0, mk(32'h7F, 1'b0, 1'b1));
    main_wait_valid();
    @(negedge clk);

    main_issue(8'h99, 8'h11, 1'b0, mk(32'h88, 1'b0, 1'b0));
    m_rst = 1'b1;
    mq.delete();
    @(negedge clk);
    chk("midreset_out_valid", 64'(m_ov), 64'd0);
    chk("midreset_diff", 64'(m_diff), 64'd0);
    chk("midreset_borrow", 64'(m_bo), 64'd0);
    chk("midreset_ovf", 64'(m_ovf), 64'd0);
    chk("midreset_in_ready", 64'(m_ir), 64'd0);
    m_rst = 1'b0;
    #1;
    chk("postreset_in_ready", 64'(m_ir), 64'd1);
    @(negedge clk);
    main_issue(8'h10, 8'h01, 1'b0, mk(32'h0F, 1'b0, 1'b0));
    main_wait_valid();
    @(negedge clk);

    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      main_issue(ra, rb, rbin, model(8, 32'(ra), 32'(rb), rbin));
    end
    n = 0;
    while (mq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("main_drain", 64'(mq.size()), 64'd0);

    n = 0;
    while (lanes_done < 3 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    chk("lanes_complete", 64'(lanes_done), 64'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // ---------------- parameter sweep instances ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    localparam int LW = (gi == 0) ? 8 : 32;
    localparam int LD = (gi == 0) ? 1 : ((gi == 1) ? 32 : 8);
    localparam int LN = LW / LD;

    logic          lrst, liv, lir, lbin, lov, lor, lbo, lovf;
    logic [LW-1:0] la, lb, ld;
    exp_t          lq[$];

    serial_subtractor #(.WIDTH(LW), .DIGIT_W(LD)) u_dut (
      .clk_i(clk), .rst_i(lrst), .in_valid_i(liv), .in_ready_o(lir),
      .a_i(la), .b_i(lb), .borrow_i(lbin), .out_valid_o(lov),
      .out_ready_i(lor), .diff_o(ld), .borrow_o(lbo), .ovf_o(lovf)
    );

    initial begin
      lor = 1'b1;
      forever begin
        @(negedge clk);
        lor = ($urandom_range(0, 3) != 0);
      end
    end

    initial begin
      int            n;
      logic [LW-1:0] ra, rb;
      logic          rbin;
      exp_t          e;
      lrst = 1'b1; liv = 1'b0; la = '0; lb = '0; lbin = 1'b0;
      repeat (3) @(negedge clk);
      lrst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 1000; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ra = LW'($urandom); rb = LW'($urandom); rbin = 1'($urandom);
        la = ra; lb = rb; lbin = rbin; liv = 1'b1;
        n = 0;
        while (!lir && n < 200) begin
          @(negedge clk);
          n++;
        end
        chk($sformatf("lane%0d_accept_ready", gi), 64'(lir), 64'd1);
        if (lir) begin
          e = model(LW, 32'(ra), 32'(rb), rbin);
          e.acc = cyc + 1;
          lq.push_back(e);
        end
        @(negedge clk);
        liv = 1'b0; la = LW'($urandom); lb = LW'($urandom);
      end
      n = 0;
      while (lq.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("lane%0d_drain", gi), 64'(lq.size()), 64'd0);
      lane_finished();
    end

    initial begin
      logic          pv, pb, po;
      logic [LW-1:0] pd;
      exp_t          e;
      pv = 1'b0; pb = 1'b0; po = 1'b0; pd = '0;
      forever begin
        @(negedge clk);
        #1;
        if (lov && !pv) begin
          if (lq.size() > 0) chk($sformatf("lane%0d_latency", gi), 64'(cyc - lq[0].acc), 64'(LN));
          else chk($sformatf("lane%0d_spurious_valid", gi), 64'(lov), 64'd0);
        end
        if (lov && pv) begin
          chk($sformatf("lane%0d_hold_diff", gi), 64'(ld), 64'(pd));
          chk($sformatf("lane%0d_hold_borrow", gi), 64'(lbo), 64'(pb));
          chk($sformatf("lane%0d_hold_ovf", gi), 64'(lovf), 64'(po));
        end
        if (lov && lor && lq.size() > 0) begin
          e = lq.pop_front();
          chk($sformatf("lane%0d_diff", gi), 64'(ld), 64'(e.diff));
          chk($sformatf("lane%0d_borrow", gi), 64'(lbo), 64'(e.bo));
          chk($sformatf("lane%0d_ovf", gi), 64'(lovf), 64'(e.ovf));
        end
        pv = lov; pd = ld; pb = lbo; po = lovf;
      end
    end
  end

endmodule
